// File: rtl/tank_bullet_if.sv
// rtl/tank_bullet_if.sv - Tank-side and bullet-side signal bundle for tank_bullet
//
// Purpose: groups the tank/keyboard inputs and the bullet outputs of one
// player's projectile controller.
// Signals:
//   keycode[7:0]       keyboard code (master -> slave)
//   tank_x/tank_y[9:0] owning tank centre (master -> slave)
//   tank_dir[1:0]      tank facing: 00 left, 01 right, 10 down, 11 up
//   barrier_collision  bullet overlaps a barrier (master -> slave)
//   enemy_hit          bullet overlaps the enemy tank (master -> slave)
//   bullet_x/y[9:0]    bullet centre (slave -> master)
//   bullet_dir[1:0]    bullet travel direction (slave -> master)
//   bullet_active      bullet drawn and live (slave -> master)
//   hit_pulse          one-frame enemy-hit pulse (slave -> master)
//   cooldown           reload in progress (slave -> master)
interface tank_bullet_if;
  logic [7:0] keycode;
  logic [9:0] tank_x;
  logic [9:0] tank_y;
  logic [1:0] tank_dir;
  logic       barrier_collision;
  logic       enemy_hit;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic [1:0] bullet_dir;
  logic       bullet_active;
  logic       hit_pulse;
  logic       cooldown;

  modport master (
    output keycode, tank_x, tank_y, tank_dir, barrier_collision, enemy_hit,
    input  bullet_x, bullet_y, bullet_dir, bullet_active, hit_pulse, cooldown
  );

  modport slave (
    input  keycode, tank_x, tank_y, tank_dir, barrier_collision, enemy_hit,
    output bullet_x, bullet_y, bullet_dir, bullet_active, hit_pulse, cooldown
  );
endinterface

// File: rtl/tank_bullet.sv
// rtl/tank_bullet.sv - Single-bullet projectile controller for one player tank
//
// Purpose: launches one bullet per fire-key press from the tank muzzle,
// advances it once per frame, retires it on enemy hit, barrier hit or
// playfield edge, then holds off further shots for a reload period.
// Ports:
//   Reset      asynchronous active-high reset
//   frame_clk  one rising edge per video frame
//   bus        tank_bullet_if.slave: tank/keyboard inputs, bullet outputs
// Optional feature macro: BULLET_BOUNCE_EN
//   defined   - the first playfield edge in a flight reverses the bullet
//               (position held that frame); the second edge retires it
//   undefined - any playfield edge retires the bullet
module tank_bullet #(
  parameter logic [7:0] FIRE_KEY        = 8'd40,
  parameter int         BULLET_STEP     = 4,
  parameter int         MUZZLE_OFFSET   = 10,
  parameter int         COOLDOWN_FRAMES = 30,
  parameter int         X_MIN           = 1,
  parameter int         X_MAX           = 639,
  parameter int         Y_MIN           = 1,
  parameter int         Y_MAX           = 479
) (
  input  logic         Reset,
  input  logic         frame_clk,
  tank_bullet_if.slave bus
);

  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES - 1);

  // All bounds arithmetic is 11 bits wide so offsets never wrap.
  localparam logic [10:0] MO         = 11'(MUZZLE_OFFSET);
  localparam logic [10:0] STEP       = 11'(BULLET_STEP);
  localparam logic [10:0] XMAX       = 11'(X_MAX);
  localparam logic [10:0] YMAX       = 11'(Y_MAX);
  localparam logic [10:0] SPAWN_MINX = 11'(X_MIN + MUZZLE_OFFSET);
  localparam logic [10:0] SPAWN_MINY = 11'(Y_MIN + MUZZLE_OFFSET);
  localparam logic [10:0] STEP_MINX  = 11'(X_MIN + BULLET_STEP);
  localparam logic [10:0] STEP_MINY  = 11'(Y_MIN + BULLET_STEP);

  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;

  state_t      state;
  logic [CW-1:0] cd_cnt;
  logic        fire_prev;
  logic [9:0]  bx, by;
  logic [1:0]  bdir;
  logic        active, hit, cd;
`ifdef BULLET_BOUNCE_EN
  logic        bounce_used;
`endif

  logic        fire_now, fire_req;
  logic [10:0] tx, ty, mx, my, bx11, by11, nx, ny;
  logic        spawn_ok, at_edge;

  assign fire_now = (bus.keycode == FIRE_KEY);
  assign fire_req = fire_now & ~fire_prev;

  assign tx   = {1'b0, bus.tank_x};
  assign ty   = {1'b0, bus.tank_y};
  assign bx11 = {1'b0, bx};
  assign by11 = {1'b0, by};

  // Muzzle position and spawn validity from the live tank pose.
  always_comb begin
    mx       = tx;
    my       = ty;
    spawn_ok = 1'b1;
    case (bus.tank_dir)
      2'b00: begin mx = tx - MO; spawn_ok = (tx >= SPAWN_MINX);  end
      2'b01: begin mx = tx + MO; spawn_ok = (tx + MO <= XMAX);   end
      2'b10: begin my = ty + MO; spawn_ok = (ty + MO <= YMAX);   end
      default: begin my = ty - MO; spawn_ok = (ty >= SPAWN_MINY); end
    endcase
  end

  // Next position and edge test from the registered bullet state.
  always_comb begin
    nx      = bx11;
    ny      = by11;
    at_edge = 1'b0;
    case (bdir)
      2'b00: begin nx = bx11 - STEP; at_edge = (bx11 < STEP_MINX);      end
      2'b01: begin nx = bx11 + STEP; at_edge = (bx11 + STEP > XMAX);    end
      2'b10: begin ny = by11 + STEP; at_edge = (by11 + STEP > YMAX);    end
      default: begin ny = by11 - STEP; at_edge = (by11 < STEP_MINY);    end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cd_cnt    <= '0;
      fire_prev <= 1'b0;
      bx        <= '0;
      by        <= '0;
      bdir      <= 2'b00;
      active    <= 1'b0;
      hit       <= 1'b0;
      cd        <= 1'b0;
`ifdef BULLET_BOUNCE_EN
      bounce_used <= 1'b0;
`endif
    end else begin
      fire_prev <= fire_now;
      hit       <= 1'b0;
      case (state)
        IDLE: begin
          active <= 1'b0;
          if (fire_req) begin
            bdir <= bus.tank_dir;
            if (spawn_ok) begin
              bx     <= mx[9:0];
              by     <= my[9:0];
              active <= 1'b1;
              state  <= FLIGHT;
`ifdef BULLET_BOUNCE_EN
              bounce_used <= 1'b0;
`endif
            end else begin
              // Muzzle would sit outside the playfield: burn the shot.
              cd_cnt <= CD_LOAD;
              cd     <= 1'b1;
              state  <= COOLDOWN;
            end
          end
        end
        FLIGHT: begin
          if (bus.enemy_hit) begin
            hit    <= 1'b1;
            active <= 1'b0;
            cd_cnt <= CD_LOAD;
            cd     <= 1'b1;
            state  <= COOLDOWN;
          end else if (bus.barrier_collision) begin
            active <= 1'b0;
            cd_cnt <= CD_LOAD;
            cd     <= 1'b1;
            state  <= COOLDOWN;
          end else if (at_edge) begin
`ifdef BULLET_BOUNCE_EN
            if (!bounce_used) begin
              bdir        <= {bdir[1], ~bdir[0]};
              bounce_used <= 1'b1;
            end else begin
              active <= 1'b0;
              cd_cnt <= CD_LOAD;
              cd     <= 1'b1;
              state  <= COOLDOWN;
            end
`else
            active <= 1'b0;
            cd_cnt <= CD_LOAD;
            cd     <= 1'b1;
            state  <= COOLDOWN;
`endif
          end else begin
            bx <= nx[9:0];
            by <= ny[9:0];
          end
        end
        COOLDOWN: begin
          // Entry frame plus COOLDOWN_FRAMES-1 decrements keeps cd high
          // for exactly COOLDOWN_FRAMES frames.
          if (cd_cnt == '0) begin
            cd    <= 1'b0;
            state <= IDLE;
          end else begin
            cd_cnt <= cd_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bullet_x      = bx;
  assign bus.bullet_y      = by;
  assign bus.bullet_dir    = bdir;
  assign bus.bullet_active = active;
  assign bus.hit_pulse     = hit;
  assign bus.cooldown      = cd;

endmodule

// File: doc/tank_bullet.md
Name: tank_bullet

Overview:
- Projectile controller for one player tank; sits directly downstream of the tank movement block.
- Consumes the tank's position and facing direction plus the keycode, and launches one bullet per fire press.
- Advances the bullet once per frame and retires it on an enemy hit, a barrier hit or a screen edge, then enforces a reload cooldown.
- Outputs drive the sprite/colour mapper and the enemy-hit/score logic.

Parameters:
- FIRE_KEY, 8'd40, keycode that fires.
- BULLET_STEP, 4, pixels moved per frame.
- MUZZLE_OFFSET, 10, spawn distance from tank centre along the facing direction.
- COOLDOWN_FRAMES, 30, frames after retirement before the next shot is accepted (>=1).
- X_MIN, 1; X_MAX, 639; Y_MIN, 1; Y_MAX, 479: playfield bounds, inclusive.

Ports:
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  clock; one edge per video frame.
- keycode  in  8  current keyboard code.
- tank_x  in  10  owning tank centre X.
- tank_y  in  10  owning tank centre Y.
- tank_dir  in  2  owning tank facing: 00 left, 01 right, 10 down, 11 up.
- barrier_collision  in  1  bullet at current bullet_x/y overlaps a barrier.
- enemy_hit  in  1  bullet at current bullet_x/y overlaps the enemy tank.
- bullet_x  out  10  bullet centre X.
- bullet_y  out  10  bullet centre Y.
- bullet_dir  out  2  bullet travel direction, same encoding as tank_dir.
- bullet_active  out  1  bullet is drawn and live.
- hit_pulse  out  1  one-frame pulse on an enemy hit.
- cooldown  out  1  reload in progress.

Behaviour:
- Reset: asynchronous, active-high; clock frame_clk. Reset is honoured mid-flight or mid-cooldown.
- Reset values: state IDLE; bullet_x=0, bullet_y=0, bullet_dir=00; bullet_active=0, hit_pulse=0, cooldown=0; cooldown counter=0; fire_prev=0.
- Fire detection:
  - fire_now = (keycode==FIRE_KEY).
  - fire_req = fire_now & ~fire_prev.
  - fire_prev is registered every frame in every state, so a held key fires only once.
- FSM IDLE:
  - bullet_active=0.
  - On fire_req: compute muzzle position as tank position ± MUZZLE_OFFSET along tank_dir; latch tank_dir into bullet_dir.
  - Bounds check is done in 11-bit arithmetic, with no wrap. Spawn is invalid if left tank_x < X_MIN+MUZZLE_OFFSET; right tank_x+MUZZLE_OFFSET > X_MAX; down tank_y+MUZZLE_OFFSET > Y_MAX; up tank_y < Y_MIN+MUZZLE_OFFSET.
  - Valid spawn: load position, set bullet_active=1, go to FLIGHT. Latency: active at the frame edge that sampled the press.
  - Invalid spawn: go directly to COOLDOWN; the bullet never becomes active.
- FSM FLIGHT (checks evaluated on the registered position, in priority order):
  1. enemy_hit: hit_pulse=1 for exactly the next frame; bullet_active=0; go to COOLDOWN.
  2. barrier_collision: bullet_active=0; go to COOLDOWN.
  3. Next step leaves bounds: bullet_active=0; go to COOLDOWN. Per direction: left x < X_MIN+BULLET_STEP; right x+BULLET_STEP > X_MAX; down y+BULLET_STEP > Y_MAX; up y < Y_MIN+BULLET_STEP.
  4. Otherwise: move BULLET_STEP along bullet_dir. Tank movement after launch has no effect.
  - fire_req is ignored in FLIGHT.
- FSM COOLDOWN:
  - On entry: counter=COOLDOWN_FRAMES-1, cooldown=1.
  - Each frame: counter decrements; at 0, go to IDLE and set cooldown=0. Cooldown therefore lasts exactly COOLDOWN_FRAMES frames.
  - fire_req is ignored in COOLDOWN.
- Position while not in FLIGHT: bullet_x, bullet_y and bullet_dir hold their last values.
- Simultaneous enemy_hit and barrier_collision: treated as an enemy hit (pulse is emitted).

Optional Feature:
- Macro: BULLET_BOUNCE_EN.
- Defined:
  - On the first out-of-bounds condition in a flight, bullet_dir flips to the opposite direction (bit0 inverted) and position holds that frame; a bounce_used flag is set.
  - A second edge retires the bullet.
  - bounce_used clears on launch and on reset.
  - Barrier and enemy priority are unchanged.
- Undefined: an edge always retires the bullet; no bounce_used register exists.

Test Plan:
- Basic flight: Reset, tank (480,240) dir 00, keycode=40 for 1 frame -> bullet_active=1 at (470,240), then 466, 462, ...; after the frame at x=2, bullet_active=0 and cooldown=1 for exactly 30 frames, then IDLE.
- Enemy hit: fire right from (100,240); assert enemy_hit on the 3rd active frame (x=118) -> hit_pulse high for exactly 1 frame, bullet_active=0, cooldown=1.
- Held key: keycode=40 held 100 frames -> exactly one launch; release then press after cooldown -> second launch.
- Invalid spawn: tank (5,240) dir 00, fire -> bullet_active stays 0, cooldown=1 for 30 frames.
- Reset mid-flight: Reset pulse during FLIGHT at (300,240) -> all outputs immediately return to reset values; the next press launches normally.
- BULLET_BOUNCE_EN: fire up from (320,20) -> y=10, 6, 2, hold at 2 with dir flipped to 10, then 6, 10, ...; retires at the bottom edge.
